port_uart_tx: RTL and testbench



---
 rtl/port_uart_tx.sv | 197 +++++++++++++++++++
 tb/tb_port_uart_tx.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_uart_tx.sv
// ---------------------------------------------------------------------------
// port_uart_tx
//
// Output-port UART transmitter that sits directly behind the processor's
// PortOut register. Every store to the port pushes one byte into a small
// FIFO. A transmit FSM pops the bytes one at a time and sends each one as an
// 8N1 frame: a start bit, eight data bits LSB first, then a stop bit. Queue
// status is exported so software can poll for full and overflow conditions.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per UART bit (>= 2)
//   FIFO_DEPTH   : number of byte entries in the FIFO (power of 2)
//   FIFO_AW      : log2(FIFO_DEPTH), width of the read/write pointers
//
// Ports
//   clk        : system clock, all state changes on the rising edge
//   reset      : asynchronous active-high reset
//   wr_en      : one-cycle push strobe from a processor store
//   wr_data    : byte to push (PortOut[7:0])
//   tx         : UART serial line, idles high, always registered
//   busy       : high whenever the FSM is not in IDLE
//   fifo_full  : high when fifo_count == FIFO_DEPTH
//   fifo_count : number of bytes currently queued
//   overflow   : sticky, set when a push arrives while the FIFO is full
// ---------------------------------------------------------------------------
module port_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int FIFO_AW      = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  output logic               tx,
  output logic               busy,
  output logic               fifo_full,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow
);

  // Width of the baud counter; it only has to reach CLKS_PER_BIT-1.
  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   DEPTH_VAL = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } txStateT;

  txStateT             state;
  logic [7:0]          fifoMem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  wrPtr;
  logic [FIFO_AW-1:0]  rdPtr;
  logic [BAUD_W-1:0]   baudCnt;
  logic [2:0]          bitIdx;
  logic [7:0]          shiftReg;

  logic                pushAccept;
  logic                popReq;
  logic                fifoNotEmpty;
  logic                baudDone;

  // Fullness is judged on the registered count only, so a pop on the same
  // edge never makes room for a write that arrives while the FIFO is full.
  assign fifo_full    = (fifo_count == DEPTH_VAL);
  assign fifoNotEmpty = (fifo_count != '0);
  assign pushAccept   = wr_en & ~fifo_full;
  assign baudDone     = (baudCnt == BAUD_LAST);

  // The FSM takes a byte either when it is idle, or at the very end of a stop
  // bit so the next start bit follows immediately with no idle gap.
  assign popReq = fifoNotEmpty &&
                  ((state == IDLE) || ((state == STOP) && baudDone));

  // Storage array. It carries no reset: the pointers and count are reset,
  // which is enough to discard every queued byte. wr_data is sampled only on
  // an accepted push, so later changes on the bus cannot corrupt the queue.
  always_ff @(posedge clk) begin
    if (pushAccept) begin
      fifoMem[wrPtr] <= wr_data;
    end
  end

  // Pointer, occupancy and overflow bookkeeping. Both pointers wrap naturally
  // because they are exactly FIFO_AW bits wide. A simultaneous push and pop
  // moves both pointers but leaves the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (pushAccept) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (popReq) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (wr_en && fifo_full) begin
        overflow <= 1'b1;
      end
      case ({pushAccept, popReq})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Transmit FSM. tx and busy are registered here alongside the state so the
  // line never has a combinational path from wr_en. Each bit lasts exactly
  // CLKS_PER_BIT cycles: the baud counter runs 0..CLKS_PER_BIT-1 and is
  // cleared on every bit boundary, which yields a 10*CLKS_PER_BIT frame.
  // In DATA the next bit is taken from shiftReg[1] because the shift and the
  // tx update happen on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          busy    <= 1'b0;
          baudCnt <= '0;
          if (popReq) begin
            shiftReg <= fifoMem[rdPtr];
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end

        START: begin
          if (baudDone) begin
            baudCnt <= '0;
            bitIdx  <= '0;
            tx      <= shiftReg[0];
            state   <= DATA;
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end

        DATA: begin
          if (baudDone) begin
            baudCnt <= '0;
            if (bitIdx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shiftReg <= {1'b0, shiftReg[7:1]};
              tx       <= shiftReg[1];
              bitIdx   <= bitIdx + 1'b1;
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end

        STOP: begin
          if (baudDone) begin
            baudCnt <= '0;
            if (popReq) begin
              shiftReg <= fifoMem[rdPtr];
              tx       <= 1'b0;
              state    <= START;
            end else begin
              tx    <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          baudCnt <= '0;
          tx      <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_port_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_port_uart_tx
//
// Self-checking bench for port_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A frame-level reference model (a byte queue plus a position inside the
// current 10-bit frame) predicts every output on every cycle. A small UART
// receiver decodes the DUT's tx line into a byte log that directed tests
// compare against the bytes they pushed. A constant table holds the expected
// bit patterns for a few single-byte frames.
// ---------------------------------------------------------------------------
module tb_port_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          tx;
  logic          busy;
  logic          fifo_full;
  logic [AW:0]   fifo_count;
  logic          overflow;

  port_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .FIFO_AW     (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  // 10-unit clock period, rising edges at 5, 15, 25 ...
  initial forever #5 clk = ~clk;

  int vecCount   = 0;
  int missCount  = 0;
  bit checkOn    = 1'b0;
  int busyCycles = 0;

  // Reference model state: queued bytes, the byte on the wire and the cycle
  // index inside its frame (-1 when the line is idle).
  logic [7:0] mQ[$];
  logic [7:0] mSent[$];
  int         mPos = -1;
  logic [7:0] mCur = 8'h00;
  logic       mOvf = 1'b0;

  logic [7:0] rxLog[$];
  logic [7:0] expQ[$];

  // Single-byte frames with their line pattern written out by hand;
  // frame[i] is the i-th bit on the wire (start first, stop last).
  typedef struct packed {
    logic [7:0] data;
    logic [9:0] frame;
  } frameVecT;

  frameVecT frameTable [5];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit en, input logic [7:0] d);
    @(negedge clk);
    wr_en   = en;
    wr_data = d;
  endtask

  function automatic logic frameBit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return d[idx-1];
  endfunction

  // One clock edge of the frame-level model. Decisions use the queue size
  // before the edge: a frame starts when the line is free and a byte waits,
  // and a push is dropped whenever the queue already held DEPTH bytes.
  task automatic modelStep();
    int  sizeBefore;
    bit  wasFull;
    sizeBefore = mQ.size();
    wasFull    = (sizeBefore == DEPTH);
    if (mPos < 0 || mPos == FRAME - 1) begin
      if (sizeBefore > 0) begin
        mCur = mQ.pop_front();
        mSent.push_back(mCur);
        mPos = 0;
      end else begin
        mPos = -1;
      end
    end else begin
      mPos++;
    end
    if (wr_en === 1'b1) begin
      if (wasFull) mOvf = 1'b1;
      else         mQ.push_back(wr_data);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset === 1'b1) begin
      mQ.delete();
      mPos = -1;
      mOvf = 1'b0;
    end else begin
      modelStep();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (checkOn) begin
      checkOutput("modelTx", tx, (mPos < 0) ? 1'b1 : frameBit(mCur, mPos / CPB));
      checkOutput("modelBusy", busy, (mPos >= 0));
      checkOutput("modelCount", fifo_count, mQ.size());
      checkOutput("modelFull", fifo_full, (mQ.size() == DEPTH));
      checkOutput("modelOverflow", overflow, mOvf);
    end
  end

  initial forever begin
    @(negedge clk);
    if (busy === 1'b1) busyCycles++;
  end

  // Minimal UART receiver: the first low sample is start-bit cycle 0, data
  // bits are sampled one cycle into each bit, and a frame is discarded if
  // reset shows up or the stop bit is not high.
  initial forever begin
    logic [7:0] b;
    bit         ok;
    @(negedge clk);
    if (reset === 1'b0 && tx === 1'b0) begin
      ok = 1'b1;
      b  = 8'h00;
      for (int c = 1; c < FRAME; c++) begin
        @(negedge clk);
        if (reset !== 1'b0) begin
          ok = 1'b0;
          break;
        end
        if ((c % CPB) == 1 && (c / CPB) >= 1 && (c / CPB) <= 8) b[c/CPB-1] = tx;
        if (c == 9 * CPB + 1 && tx !== 1'b1) ok = 1'b0;
      end
      if (ok) rxLog.push_back(b);
    end
  end

  task automatic doReset();
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    rxLog.delete();
    mSent.delete();
    busyCycles = 0;
  endtask

  task automatic waitIdle(input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && fifo_count == '0) return;
    end
    checkOutput("waitIdleTimeout", 32'd0, 32'd1);
  endtask

  task automatic waitPos(input int target, input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      if (mPos == target) return;
    end
    checkOutput("waitPosTimeout", 32'd0, 32'd1);
  endtask

  task automatic compareRx(input string name);
    int n;
    checkOutput({name, "Size"}, rxLog.size(), expQ.size());
    n = (rxLog.size() < expQ.size()) ? rxLog.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput(name, rxLog[i], expQ[i]);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    frameTable[0] = {8'hA5, 10'b11_0100_1010};
    frameTable[1] = {8'h00, 10'b10_0000_0000};
    frameTable[2] = {8'hFF, 10'b11_1111_1110};
    frameTable[3] = {8'h80, 10'b11_0000_0000};
    frameTable[4] = {8'h3C, 10'b10_0111_1000};

    repeat (2) @(negedge clk);
    checkOutput("resetTx", tx, 1'b1);
    checkOutput("resetBusy", busy, 1'b0);
    checkOutput("resetCount", fifo_count, 0);
    checkOutput("resetFull", fifo_full, 1'b0);
    checkOutput("resetOverflow", overflow, 1'b0);
    #1 reset = 1'b0;
    checkOn = 1'b1;

    // Table: one byte at a time, full frame compared bit by bit.
    for (int v = 0; v < 5; v++) begin
      applyStimulus(1'b1, frameTable[v].data);
      applyStimulus(1'b0, ~frameTable[v].data);
      checkOutput("tableCount", fifo_count, 1);
      checkOutput("tableIdleBusy", busy, 1'b0);
      for (int i = 0; i < FRAME; i++) begin
        @(negedge clk);
        checkOutput("tableTx", tx, frameTable[v].frame[i/CPB]);
        checkOutput("tableBusy", busy, 1'b1);
      end
      @(negedge clk);
      checkOutput("tableEndBusy", busy, 1'b0);
      checkOutput("tableEndTx", tx, 1'b1);
      checkOutput("tableEndCount", fifo_count, 0);
    end

    // Back-to-back frames with no idle gap.
    doReset();
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b0, 8'h5A);
    waitIdle(4 * FRAME);
    checkOutput("b2bBusyCycles", busyCycles, 2 * FRAME);
    expQ.delete();
    expQ.push_back(8'h01);
    expQ.push_back(8'hFF);
    compareRx("b2bRx");

    // Overflow: one byte in flight, five more pushed, the fifth is dropped.
    doReset();
    applyStimulus(1'b1, 8'hC0);
    applyStimulus(1'b0, 8'h00);
    repeat (2) @(negedge clk);
    checkOutput("ovfInFlight", busy, 1'b1);
    for (int k = 1; k <= 5; k++) applyStimulus(1'b1, 8'(8'hC0 + k));
    checkOutput("ovfFullCount", fifo_count, 4);
    checkOutput("ovfFull", fifo_full, 1'b1);
    checkOutput("ovfNotYet", overflow, 1'b0);
    applyStimulus(1'b0, 8'hEE);
    checkOutput("ovfSet", overflow, 1'b1);
    checkOutput("ovfCountHeld", fifo_count, 4);
    waitIdle(6 * FRAME);
    checkOutput("ovfBusyCycles", busyCycles, 5 * FRAME);
    checkOutput("ovfDrained", fifo_count, 0);
    checkOutput("ovfSticky", overflow, 1'b1);
    expQ.delete();
    for (int k = 0; k < 5; k++) expQ.push_back(8'(8'hC0 + k));
    compareRx("ovfRx");

    // Push and pop on the same edge with two bytes queued.
    doReset();
    applyStimulus(1'b1, 8'h3A);
    applyStimulus(1'b1, 8'h3B);
    applyStimulus(1'b1, 8'h3C);
    applyStimulus(1'b0, 8'h00);
    checkOutput("ppQueued", fifo_count, 2);
    waitPos(FRAME - 2, 2 * FRAME);
    checkOutput("ppBefore", fifo_count, 2);
    applyStimulus(1'b1, 8'h3D);
    applyStimulus(1'b0, 8'h00);
    checkOutput("ppAfter", fifo_count, 2);
    checkOutput("ppStartBit", tx, 1'b0);
    checkOutput("ppBusy", busy, 1'b1);
    waitIdle(5 * FRAME);
    expQ.delete();
    for (int k = 0; k < 4; k++) expQ.push_back(8'(8'h3A + k));
    compareRx("ppRx");

    // Asynchronous reset in the middle of data bit 3 with two bytes queued.
    doReset();
    applyStimulus(1'b1, 8'h51);
    applyStimulus(1'b1, 8'h52);
    applyStimulus(1'b1, 8'h53);
    applyStimulus(1'b0, 8'h00);
    waitPos(4 * CPB + 1, 2 * FRAME);
    checkOutput("arstInFrame", busy, 1'b1);
    checkOutput("arstQueued", fifo_count, 2);
    #1 reset = 1'b1;
    #1;
    checkOutput("arstTx", tx, 1'b1);
    checkOutput("arstBusy", busy, 1'b0);
    checkOutput("arstCount", fifo_count, 0);
    checkOutput("arstFull", fifo_full, 1'b0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    busyCycles = 0;
    rxLog.delete();
    repeat (3 * FRAME) @(negedge clk);
    checkOutput("arstNoBusy", busyCycles, 0);
    checkOutput("arstNoFrames", rxLog.size(), 0);
    checkOutput("arstLineHigh", tx, 1'b1);

    // Pointer wrap: nine bytes in bursts of three.
    doReset();
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 8'(3 * b + k));
      applyStimulus(1'b0, 8'hFF);
      waitIdle(5 * FRAME);
    end
    expQ.delete();
    for (int k = 0; k < 9; k++) expQ.push_back(8'(k));
    compareRx("wrapRx");

    // Randomized pushes against the model.
    doReset();
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 99) < 12), 8'($urandom));
    end
    applyStimulus(1'b0, 8'h00);
    waitIdle(7 * FRAME);
    expQ = mSent;
    compareRx("randRx");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
